spiker_frame_buffer: RTL and testbench

- Next-generation spike input stage: captures register-file spike words into full-width frames on `sample_i` and queues them in a DEPTH-entry frame FIFO.
- Frames are delivered to the spiker core over a valid/ready handshake, with zero-masking of padding bits and per-frame repetition (timesteps).
- Drops on overflow are reported through a sticky flag and a drop counter.
- Sits between the spiker_adapter register file and the spiker core input.

---
 rtl/spiker_frame_buffer.sv | 149 ++++++++++++++
 tb/tb_spiker_frame_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiker_frame_buffer.sv
// Spike frame buffer: captures the spike register file as one full-width
// frame per sample request, queues frames in a DEPTH-entry flop FIFO and
// delivers each head frame to the spiker core repeat_i times over a
// valid/ready handshake. Overflowing samples are dropped and counted.
module spiker_frame_buffer #(
  parameter  int WIDTH      = 32,
  parameter  int N_REG      = 25,
  parameter  int N_SPIKES   = 784,
  parameter  int DEPTH      = 4,
  parameter  int RPT_W      = 8,
  parameter  int CNT_W      = 16,
  localparam int DATA_WIDTH = N_REG * WIDTH,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_mode_i,
  input  logic [DATA_WIDTH-1:0] spikes_i,
  input  logic                  sample_i,
  input  logic                  clear_i,
  input  logic [RPT_W-1:0]      repeat_i,
  output logic [DATA_WIDTH-1:0] frame_o,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic                  frame_last_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  overflow_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Ones over the real spike bits, zeros over the padding above N_SPIKES.
  localparam logic [DATA_WIDTH-1:0] VALID_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - N_SPIKES);
  localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]      FULL_LVL   = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [RPT_W-1:0]      rep_cnt;
  logic                  overflow_q;
  logic [CNT_W-1:0]      drop_cnt_q;

  logic                  valid;
  logic [RPT_W-1:0]      rpt_eff;
  logic                  last;
  logic                  handshake;
  logic                  pop;
  logic                  take;
  logic                  full;
  logic                  push;
  logic                  drop;

  // DFT mode has no functional effect on this block.
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode: repetition, pop, push and drop decisions for this cycle.
  always_comb begin
    valid     = (level_q != '0);
    rpt_eff   = (repeat_i == '0) ? RPT_W'(1) : repeat_i;
    last      = valid && (rep_cnt >= (rpt_eff - RPT_W'(1)));
    handshake = valid && frame_ready_i && !clear_i;
    pop       = handshake && last;
    take      = sample_i && !clear_i;
    full      = (level_q == FULL_LVL);
    push      = take && (!full || pop);
    drop      = take && full && !pop;
  end

  assign frame_valid_o = valid;
  assign frame_last_o  = last;
  assign frame_o       = valid ? mem[rd_ptr] : '0;
  assign level_o       = level_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

  // Frame storage: write the masked spike words at the tail on each push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= spikes_i & VALID_MASK;
    end
  end

  // Queue bookkeeping: pointers and fill level; clear empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Repetition counter for the head frame, restarted whenever the head pops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_cnt <= '0;
    end else if (clear_i || pop) begin
      rep_cnt <= '0;
    end else if (handshake) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Drop reporting: sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spiker_frame_buffer.sv
// Testbench for spiker_frame_buffer: directed scenarios plus a randomized
// run, all checked every cycle against a queue-based behavioural model.
module tb_spiker_frame_buffer;

  localparam int WIDTH    = 32;
  localparam int N_REG    = 25;
  localparam int N_SPIKES = 784;
  localparam int DEPTH    = 4;
  localparam int RPT_W    = 8;
  localparam int CNT_W    = 4;
  localparam int DW       = N_REG * WIDTH;
  localparam int LVL_W    = $clog2(DEPTH + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             test_mode;
  logic [DW-1:0]    spikes;
  logic             sample;
  logic             clear;
  logic [RPT_W-1:0] rpt;
  logic [DW-1:0]    frame;
  logic             frame_valid;
  logic             frame_ready;
  logic             frame_last;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [DW-1:0] mq[$];
  int            m_rep;
  bit            m_ovf;
  int            m_drop;
  logic [DW-1:0] valid_mask;

  logic [DW-1:0] fr [6];
  logic [DW-1:0] d;

  spiker_frame_buffer #(
    .WIDTH(WIDTH), .N_REG(N_REG), .N_SPIKES(N_SPIKES),
    .DEPTH(DEPTH), .RPT_W(RPT_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .test_mode_i(test_mode), .spikes_i(spikes),
    .sample_i(sample), .clear_i(clear), .repeat_i(rpt), .frame_o(frame),
    .frame_valid_o(frame_valid), .frame_ready_i(frame_ready),
    .frame_last_o(frame_last), .level_o(level), .overflow_o(overflow),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic r,
                               input logic [RPT_W-1:0] rp, input logic [DW-1:0] data);
    sample      = s;
    clear       = c;
    frame_ready = r;
    rpt         = rp;
    spikes      = data;
  endtask

  function automatic logic [DW-1:0] randomFrame();
    logic [DW-1:0] f;
    for (int i = 0; i < N_REG; i++) f[i*WIDTH +: WIDTH] = $urandom;
    return f;
  endfunction

  function automatic int effRepeat();
    return (rpt == 0) ? 1 : int'(rpt);
  endfunction

  task automatic modelReset();
    mq.delete();
    m_rep  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Advance the model by one clock according to the block's rules.
  task automatic modelStep();
    bit was_full, hs, lst;
    if (rst) begin
      modelReset();
      return;
    end
    if (clear) begin
      modelReset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    hs       = (mq.size() > 0) && frame_ready;
    lst      = hs && (m_rep >= effRepeat() - 1);
    if (hs) begin
      if (lst) begin
        void'(mq.pop_front());
        m_rep = 0;
      end else begin
        m_rep++;
      end
    end
    if (sample) begin
      if (!was_full || lst) begin
        mq.push_back(spikes & valid_mask);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < CNT_MAX) m_drop++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit            ev;
      logic [DW-1:0] ef;
      ev = (mq.size() > 0);
      ef = ev ? mq[0] : '0;
      checkOutput("valid", DW'(frame_valid), DW'(ev));
      checkOutput("frame", frame, ef);
      checkOutput("last", DW'(frame_last), DW'(ev && (m_rep >= effRepeat() - 1)));
      checkOutput("level", DW'(level), DW'(mq.size()));
      checkOutput("overflow", DW'(overflow), DW'(m_ovf));
      checkOutput("drop_cnt", DW'(drop_cnt), DW'(m_drop));
    end
  end

  initial begin
    for (int i = 0; i < DW; i++) valid_mask[i] = (i < N_SPIKES);
    test_mode = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    modelReset();
    #2;
    checkOutput("rst_valid", DW'(frame_valid), '0);
    checkOutput("rst_frame", frame, '0);
    checkOutput("rst_level", DW'(level), '0);
    checkOutput("rst_drop", DW'(drop_cnt), '0);
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Padding mask and single-shot delivery
    $display("[TB] masked single frame");
    d = '0;
    d[31:0] = 32'hFFFF_FFFF;
    d[799:768] = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, d);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, '0);
    checkOutput("t1_valid", DW'(frame_valid), DW'(1));
    checkOutput("t1_last", DW'(frame_last), DW'(1));
    checkOutput("t1_word0", DW'(frame[31:0]), DW'(32'hFFFF_FFFF));
    checkOutput("t1_pad", DW'(frame[799:784]), '0);
    checkOutput("t1_top", DW'(frame[783:768]), DW'(16'hFFFF));
    tick();
    checkOutput("t1_empty", DW'(frame_valid), '0);
    checkOutput("t1_level", DW'(level), '0);

    // Three repetitions with ready toggling 1,0,1,1
    $display("[TB] repetition");
    d = randomFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, d);
    tick();
    foreach (fr[i]) fr[i] = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, (k != 1), 8'd3, '0);
      checkOutput("t2_frame", frame, d & valid_mask);
      checkOutput("t2_last", DW'(frame_last), DW'(k == 3));
      tick();
    end
    checkOutput("t2_done", DW'(frame_valid), '0);

    // Overflow: six samples into a four-deep queue with ready low
    $display("[TB] overflow");
    for (int k = 0; k < 6; k++) begin
      fr[k] = randomFrame();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, fr[k]);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
    checkOutput("t3_level", DW'(level), DW'(4));
    checkOutput("t3_ovf", DW'(overflow), DW'(1));
    checkOutput("t3_drop", DW'(drop_cnt), DW'(2));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, '0);
      checkOutput("t3_order", frame, fr[k] & valid_mask);
      tick();
    end
    checkOutput("t3_empty", DW'(frame_valid), '0);

    // Push coinciding with final-repetition pop at full
    $display("[TB] push and pop at full");
    for (int k = 0; k < 4; k++) begin
      fr[k] = randomFrame();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, fr[k]);
      tick();
    end
    fr[4] = randomFrame();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, fr[4]);
    checkOutput("t4_last", DW'(frame_last), DW'(1));
    tick();
    checkOutput("t4_level", DW'(level), DW'(4));
    checkOutput("t4_drop", DW'(drop_cnt), DW'(2));
    for (int k = 1; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, '0);
      checkOutput("t4_order", frame, fr[k] & valid_mask);
      tick();
    end

    // Clear with a simultaneous sample
    $display("[TB] clear");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, randomFrame());
      tick();
    end
    checkOutput("t5_drop_pre", DW'(drop_cnt), DW'(2));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, randomFrame());
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
    checkOutput("t5_level", DW'(level), '0);
    checkOutput("t5_ovf", DW'(overflow), '0);
    checkOutput("t5_drop", DW'(drop_cnt), '0);
    checkOutput("t5_valid", DW'(frame_valid), '0);

    // Drop counter saturation
    $display("[TB] saturation");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, randomFrame());
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
    checkOutput("t6_sat", DW'(drop_cnt), DW'(CNT_MAX));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, '0);
    tick();

    // Asynchronous reset in the middle of a delivery
    $display("[TB] async reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, randomFrame());
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd2, '0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t7_valid", DW'(frame_valid), '0);
    checkOutput("t7_level", DW'(level), '0);
    checkOutput("t7_frame", frame, '0);
    tick();
    rst = 1'b0;
    d = randomFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, d);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
    checkOutput("t7_after", frame, d & valid_mask);
    checkOutput("t7_vafter", DW'(frame_valid), DW'(1));

    // Randomized traffic
    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 60, RPT_W'($urandom_range(0, 3)), randomFrame());
      tick();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
